// File: rtl/edge_walker.sv
// edge_walker: steps the edge function e = a*x + b*y + c over an inclusive bounding box in
// row-major order, emitting one valid/ready handshaked record per pixel. The per-pixel cost is
// a single add: e grows by a along a row, and each new row restarts from row_e + b.
module edge_walker (
    input  logic               clock,
    input  logic               reset,
    input  logic               trigger,
    input  logic signed [17:0] a,
    input  logic signed [17:0] b,
    input  logic signed [17:0] c,
    input  logic        [9:0]  xmin,
    input  logic        [9:0]  xmax,
    input  logic        [9:0]  ymin,
    input  logic        [9:0]  ymax,
    output logic               busy,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic        [9:0]  pix_x,
    output logic        [9:0]  pix_y,
    output logic signed [31:0] pix_e,
    output logic               pix_inside,
    output logic               done
);

    typedef enum logic [2:0] {
        StIdle,
        StMul,
        StAdd,
        StWalk,
        StFin
    } state_e;

    state_e state_q, state_d;

    // Latched job parameters
    logic signed [17:0] a_q, a_d;
    logic signed [17:0] b_q, b_d;
    logic signed [17:0] c_q, c_d;
    logic        [9:0]  xmin_q, xmin_d;
    logic        [9:0]  xmax_q, xmax_d;
    logic        [9:0]  ymin_q, ymin_d;
    logic        [9:0]  ymax_q, ymax_d;

    // Products and walk state
    logic signed [31:0] prod_a_q, prod_a_d;
    logic signed [31:0] prod_b_q, prod_b_d;
    logic signed [31:0] e_q, e_d;
    logic signed [31:0] row_e_q, row_e_d;
    logic        [9:0]  x_q, x_d;
    logic        [9:0]  y_q, y_d;

    // 32-bit operands: coefficients sign-extended, coordinates zero-extended
    logic signed [31:0] a_ext, b_ext, c_ext, xmin_ext, ymin_ext;
    logic               accept;

    assign a_ext    = {{14{a_q[17]}}, a_q};
    assign b_ext    = {{14{b_q[17]}}, b_q};
    assign c_ext    = {{14{c_q[17]}}, c_q};
    assign xmin_ext = {22'd0, xmin_q};
    assign ymin_ext = {22'd0, ymin_q};
    assign accept   = (state_q == StWalk) && pix_ready;

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        xmin_d   = xmin_q;
        xmax_d   = xmax_q;
        ymin_d   = ymin_q;
        ymax_d   = ymax_q;
        prod_a_d = prod_a_q;
        prod_b_d = prod_b_q;
        e_d      = e_q;
        row_e_d  = row_e_q;
        x_d      = x_q;
        y_d      = y_q;

        unique case (state_q)
            StIdle: begin
                if (trigger) begin
                    a_d     = a;
                    b_d     = b;
                    c_d     = c;
                    xmin_d  = xmin;
                    xmax_d  = xmax;
                    ymin_d  = ymin;
                    ymax_d  = ymax;
                    state_d = StMul;
                end
            end
            StMul: begin
                prod_a_d = a_ext * xmin_ext;
                prod_b_d = b_ext * ymin_ext;
                state_d  = StAdd;
            end
            StAdd: begin
                e_d     = prod_a_q + prod_b_q + c_ext;
                row_e_d = prod_a_q + prod_b_q + c_ext;
                x_d     = xmin_q;
                y_d     = ymin_q;
                // Empty box: no records, straight to the done pulse
                if ((xmin_q > xmax_q) || (ymin_q > ymax_q)) begin
                    state_d = StFin;
                end else begin
                    state_d = StWalk;
                end
            end
            StWalk: begin
                if (accept) begin
                    // Equality tests keep a 0..1023 box from wrapping the coordinates
                    if (x_q != xmax_q) begin
                        x_d = x_q + 10'd1;
                        e_d = e_q + a_ext;
                    end else if (y_q != ymax_q) begin
                        x_d     = xmin_q;
                        y_d     = y_q + 10'd1;
                        row_e_d = row_e_q + b_ext;
                        e_d     = row_e_q + b_ext;
                    end else begin
                        state_d = StFin;
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous reset; reset abandons any walk in progress
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            xmin_q   <= '0;
            xmax_q   <= '0;
            ymin_q   <= '0;
            ymax_q   <= '0;
            prod_a_q <= '0;
            prod_b_q <= '0;
            e_q      <= '0;
            row_e_q  <= '0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            xmin_q   <= xmin_d;
            xmax_q   <= xmax_d;
            ymin_q   <= ymin_d;
            ymax_q   <= ymax_d;
            prod_a_q <= prod_a_d;
            prod_b_q <= prod_b_d;
            e_q      <= e_d;
            row_e_q  <= row_e_d;
            x_q      <= x_d;
            y_q      <= y_d;
        end
    end

    // Outputs come straight from registers, so they hold while the consumer stalls
    always_comb begin
        busy       = (state_q != StIdle);
        pix_valid  = (state_q == StWalk);
        done       = (state_q == StFin);
        pix_x      = x_q;
        pix_y      = y_q;
        pix_e      = e_q;
        // Gated so the idle/reset value is 0 even though e_q = 0 there
        pix_inside = (state_q == StWalk) && !e_q[31];
    end

endmodule

// File: tb/tb_edge_walker.sv
// tb_edge_walker: directed scenarios with hand-computed records for edge_walker.
module tb_edge_walker;

    logic               clock;
    logic               reset;
    logic               trigger;
    logic signed [17:0] a, b, c;
    logic        [9:0]  xmin, xmax, ymin, ymax;
    logic               busy, pix_valid, pix_ready, pix_inside, done;
    logic        [9:0]  pix_x, pix_y;
    logic signed [31:0] pix_e;

    int checks   = 0;
    int failures = 0;

    edge_walker dut (
        .clock      (clock),
        .reset      (reset),
        .trigger    (trigger),
        .a          (a),
        .b          (b),
        .c          (c),
        .xmin       (xmin),
        .xmax       (xmax),
        .ymin       (ymin),
        .ymax       (ymax),
        .busy       (busy),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_e      (pix_e),
        .pix_inside (pix_inside),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge, then settle before sampling
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Present a job and let the trigger-sampling edge pass
    task automatic start(input int ca, input int cb, input int cc, input int x0, input int x1,
                         input int y0, input int y1);
        a       = 18'(ca);
        b       = 18'(cb);
        c       = 18'(cc);
        xmin    = 10'(x0);
        xmax    = 10'(x1);
        ymin    = 10'(y0);
        ymax    = 10'(y1);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
    endtask

    // Check the presented record, then take the edge that accepts it (pix_ready assumed high)
    task automatic expect_rec(input string tag, input int ex, input int ey, input int ee);
        check({tag, ".valid"}, 64'(pix_valid), 64'd1);
        check({tag, ".x"}, 64'(pix_x), 64'(ex));
        check({tag, ".y"}, 64'(pix_y), 64'(ey));
        check({tag, ".e"}, 64'(pix_e), 64'(ee));
        check({tag, ".in"}, 64'(pix_inside), (ee >= 0) ? 64'd1 : 64'd0);
        tick();
    endtask

    // After the final acceptance: one done pulse, then idle
    task automatic expect_fin(input string tag);
        check({tag, ".fin_done"}, 64'(done), 64'd1);
        check({tag, ".fin_valid"}, 64'(pix_valid), 64'd0);
        tick();
        check({tag, ".idle_done"}, 64'(done), 64'd0);
        check({tag, ".idle_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int dones;
        reset     = 1'b1;
        trigger   = 1'b0;
        pix_ready = 1'b1;
        a = '0; b = '0; c = '0;
        xmin = '0; xmax = '0; ymin = '0; ymax = '0;
        tick();
        tick();
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.valid", 64'(pix_valid), 64'd0);
        check("rst.done", 64'(done), 64'd0);
        check("rst.x", 64'(pix_x), 64'd0);
        check("rst.y", 64'(pix_y), 64'd0);
        check("rst.e", 64'(pix_e), 64'd0);
        check("rst.in", 64'(pix_inside), 64'd0);
        reset = 1'b0;
        tick();

        // Scenario 1: e(249,116) = -32619 + 11368 + 21251 = 0
        start(-131, 98, 21251, 249, 251, 116, 116);
        tick();
        tick();
        expect_rec("s1r0", 249, 116, 0);
        expect_rec("s1r1", 250, 116, -131);
        expect_rec("s1r2", 251, 116, -262);
        expect_fin("s1");

        // Scenario 2: latency counted with the trigger-sampling edge as the first
        start(1, 1, -1, 0, 1, 0, 1);
        check("s2.lat1_valid", 64'(pix_valid), 64'd0);
        check("s2.lat1_busy", 64'(busy), 64'd1);
        tick();
        check("s2.lat2_valid", 64'(pix_valid), 64'd0);
        tick();
        expect_rec("s2r0", 0, 0, -1);
        expect_rec("s2r1", 1, 0, 0);
        expect_rec("s2r2", 0, 1, 0);
        expect_rec("s2r3", 1, 1, 1);
        expect_fin("s2");

        // Scenario 3: stall the second record for 5 cycles
        start(1, 1, -1, 0, 1, 0, 1);
        tick();
        tick();
        expect_rec("s3r0", 0, 0, -1);
        pix_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("s3.hold_valid", 64'(pix_valid), 64'd1);
            check("s3.hold_x", 64'(pix_x), 64'd1);
            check("s3.hold_y", 64'(pix_y), 64'd0);
            check("s3.hold_e", 64'(pix_e), 64'd0);
            check("s3.hold_in", 64'(pix_inside), 64'd1);
            tick();
        end
        pix_ready = 1'b1;
        expect_rec("s3r1", 1, 0, 0);
        expect_rec("s3r2", 0, 1, 0);
        expect_rec("s3r3", 1, 1, 1);
        expect_fin("s3");

        // Scenario 4: empty box, done on the third edge; retrigger in first idle cycle
        start(3, 4, 5, 5, 4, 0, 0);
        check("s4.e1_valid", 64'(pix_valid), 64'd0);
        tick();
        check("s4.e2_valid", 64'(pix_valid), 64'd0);
        check("s4.e2_done", 64'(done), 64'd0);
        tick();
        expect_fin("s4");
        // Back-to-back: 1-pixel job triggered immediately
        start(-2, 0, 1, 7, 7, 9, 9);
        check("s4b.busy", 64'(busy), 64'd1);
        tick();
        tick();
        expect_rec("s4b", 7, 9, -13);
        expect_fin("s4b");

        // Scenario 5: reset after 2 records of a 4x4 walk, then a fresh 16-record walk
        start(2, -3, 1, 0, 3, 0, 3);
        tick();
        tick();
        expect_rec("s5a0", 0, 0, 1);
        expect_rec("s5a1", 1, 0, 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("s5.rst_busy", 64'(busy), 64'd0);
        check("s5.rst_valid", 64'(pix_valid), 64'd0);
        check("s5.rst_done", 64'(done), 64'd0);
        tick();
        check("s5.post_done", 64'(done), 64'd0);
        start(2, -3, 1, 0, 3, 0, 3);
        tick();
        tick();
        dones = 0;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 4; x++) begin
                if (done) dones++;
                expect_rec("s5b", x, y, 2 * x - 3 * y + 1);
            end
        end
        check("s5.no_early_done", 64'(dones), 64'd0);
        expect_fin("s5b");

        // Scenario 6: trigger with different job during the walk is ignored
        start(1, 1, -1, 0, 1, 0, 1);
        tick();
        tick();
        a = 18'sd500; b = -18'sd7; c = 18'sd9;
        xmin = 10'd100; xmax = 10'd200; ymin = 10'd50; ymax = 10'd60;
        trigger = 1'b1;
        expect_rec("s6r0", 0, 0, -1);
        expect_rec("s6r1", 1, 0, 0);
        expect_rec("s6r2", 0, 1, 0);
        trigger = 1'b0;
        expect_rec("s6r3", 1, 1, 1);
        expect_fin("s6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
